// File: rtl/window_sum_stage.sv
// window_sum_stage
// Sliding-window modular sum over the most recent DEPTH accepted words.
// Each accepted word updates a running sum (add new, subtract the word that
// falls out of the window) and the result is queued in a 2-entry skid FIFO
// with valid/ready handshakes on both sides.
//
// Optional feature macro: WINDOW_SUM_FLUSH_EN
//   When defined, a 'flush' input is present. Flush clears the window
//   (fill, sum, write pointer) but leaves the output FIFO untouched.
//   A word accepted in the same cycle as flush starts a fresh window.
//   When undefined, the window is cleared only by rst.

module window_sum_stage #(
  parameter int WIDTH = 100,
  parameter int DEPTH = 10
) (
  input  logic             clk,
  input  logic             rst,
`ifdef WINDOW_SUM_FLUSH_EN
  input  logic             flush,
`endif
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             window_full
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] FULL_FILL = FILL_W'(DEPTH);

  // Window history and running state
  logic [WIDTH-1:0]  histBuf [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [FILL_W-1:0] fill;
  logic [WIDTH-1:0]  sum;

  // Output skid FIFO: head is what the consumer sees, tail is the overflow slot
  logic [WIDTH-1:0]  fifoHead;
  logic [WIDTH-1:0]  fifoTail;
  logic [1:0]        occ;

  // Handshake and next-state helpers
  logic              flushNow;
  logic              accept;
  logic              pop;
  logic [PTR_W-1:0]  wptrEff;
  logic [FILL_W-1:0] fillEff;
  logic [WIDTH-1:0]  sumEff;
  logic [WIDTH-1:0]  oldWord;
  logic [WIDTH-1:0]  sumNext;

`ifdef WINDOW_SUM_FLUSH_EN
  assign flushNow = flush;
`else
  assign flushNow = 1'b0;
`endif

  // in_ready depends only on registered occupancy, so there is no
  // combinational path from out_ready or in_valid back to the upstream stage.
  assign in_ready    = (occ < 2'd2);
  assign out_valid   = (occ != 2'd0);
  assign out_data    = fifoHead;
  assign window_full = (fill == FULL_FILL);

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // Effective window state seen by this cycle's word: a flush takes effect
  // first so a simultaneous word opens a fresh window. The evicted word only
  // counts once the window is full; before that the slot holds stale data.
  always_comb begin
    wptrEff = flushNow ? '0 : wptr;
    fillEff = flushNow ? '0 : fill;
    sumEff  = flushNow ? '0 : sum;
    oldWord = (fillEff == FULL_FILL) ? histBuf[wptrEff] : '0;
    sumNext = sumEff + in_data - oldWord;
  end

  // Window update: store the word, advance the circular pointer, saturate fill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      fill <= '0;
      sum  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        histBuf[i] <= '0;
      end
    end else if (accept) begin
      histBuf[wptrEff] <= in_data;
      wptr <= (wptrEff == LAST_PTR) ? '0 : wptrEff + 1'b1;
      fill <= (fillEff == FULL_FILL) ? FULL_FILL : fillEff + 1'b1;
      sum  <= sumNext;
    end else if (flushNow) begin
      wptr <= '0;
      fill <= '0;
      sum  <= '0;
    end
  end

  // Output FIFO: push the new sum on accept, shift tail to head on pop.
  // Push and pop together only happen at occ=1 (occ=2 blocks accept,
  // occ=0 blocks pop), in which case the head is simply replaced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifoHead <= '0;
      fifoTail <= '0;
      occ      <= 2'd0;
    end else begin
      case ({accept, pop})
        2'b11: begin
          fifoHead <= sumNext;
        end
        2'b10: begin
          if (occ == 2'd0) begin
            fifoHead <= sumNext;
            occ      <= 2'd1;
          end else begin
            fifoTail <= sumNext;
            occ      <= 2'd2;
          end
        end
        2'b01: begin
          if (occ == 2'd2) begin
            fifoHead <= fifoTail;
            occ      <= 2'd1;
          end else begin
            occ      <= 2'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_window_sum_stage.sv
// tb_window_sum_stage
// Drives a small instance (WIDTH=8, DEPTH=4) and a default instance
// (WIDTH=100, DEPTH=10). A queue-based reference model keeps the last DEPTH
// accepted words and the list of undelivered sums; table vectors and short
// hand-written sequences cover the listed corner cases.

module tb_window_sum_stage;

  localparam int S_DEPTH = 4;
  localparam int B_DEPTH = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Small instance signals
  logic [7:0]  sInData;
  logic        sInValid, sInReady, sOutValid, sOutReady, sFull, sFlush;
  logic [7:0]  sOutData;

  // Default instance signals
  logic [99:0] bInData;
  logic        bInValid, bInReady, bOutValid, bOutReady, bFull, bFlush;
  logic [99:0] bOutData;

  window_sum_stage #(.WIDTH(8), .DEPTH(S_DEPTH)) dutSmall (
    .clk(clk), .rst(rst),
`ifdef WINDOW_SUM_FLUSH_EN
    .flush(sFlush),
`endif
    .in_data(sInData), .in_valid(sInValid), .in_ready(sInReady),
    .out_data(sOutData), .out_valid(sOutValid), .out_ready(sOutReady),
    .window_full(sFull)
  );

  window_sum_stage dutBig (
    .clk(clk), .rst(rst),
`ifdef WINDOW_SUM_FLUSH_EN
    .flush(bFlush),
`endif
    .in_data(bInData), .in_valid(bInValid), .in_ready(bInReady),
    .out_data(bOutData), .out_valid(bOutValid), .out_ready(bOutReady),
    .window_full(bFull)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0]  sHist[$];
  logic [7:0]  sOutQ[$];
  logic [99:0] bHist[$];
  logic [99:0] bOutQ[$];

  typedef struct {
    logic       doReset;
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       expValid;
    logic [7:0] expData;
    logic       expFull;
  } vec_t;

  vec_t tbl[11];

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic checkWord(input string name, input logic [99:0] act, input logic [99:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic resetAll();
    rst = 1'b1;
    sInValid = 1'b0; sInData = '0; sOutReady = 1'b0; sFlush = 1'b0;
    bInValid = 1'b0; bInData = '0; bOutReady = 1'b0; bFlush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sHist.delete(); sOutQ.delete();
    bHist.delete(); bOutQ.delete();
    @(posedge clk);
    #1;
  endtask

  // One cycle on the small instance, checked against the model
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r, input logic fl);
    bit acc, pp;
    logic [7:0] s;
    sInValid = v; sInData = d; sOutReady = r; sFlush = fl;
    checkBit("s.in_ready", sInReady, sOutQ.size() < 2);
    checkBit("s.out_valid", sOutValid, sOutQ.size() > 0);
    if (sOutQ.size() > 0) checkWord("s.out_data", 100'(sOutData), 100'(sOutQ[0]));
    acc = v && (sOutQ.size() < 2);
    pp  = r && (sOutQ.size() > 0);
    @(posedge clk);
    #1;
    if (pp) void'(sOutQ.pop_front());
    if (fl) sHist.delete();
    if (acc) begin
      sHist.push_back(d);
      if (sHist.size() > S_DEPTH) void'(sHist.pop_front());
      s = '0;
      foreach (sHist[i]) s += sHist[i];
      sOutQ.push_back(s);
    end
    checkBit("s.window_full", sFull, sHist.size() == S_DEPTH);
    sInValid = 1'b0; sFlush = 1'b0;
  endtask

  // One cycle on the default instance, checked against the model
  task automatic stepBig(input logic v, input logic [99:0] d, input logic r);
    bit acc, pp;
    logic [99:0] s;
    bInValid = v; bInData = d; bOutReady = r;
    checkBit("b.in_ready", bInReady, bOutQ.size() < 2);
    checkBit("b.out_valid", bOutValid, bOutQ.size() > 0);
    if (bOutQ.size() > 0) checkWord("b.out_data", bOutData, bOutQ[0]);
    acc = v && (bOutQ.size() < 2);
    pp  = r && (bOutQ.size() > 0);
    @(posedge clk);
    #1;
    if (pp) void'(bOutQ.pop_front());
    if (acc) begin
      bHist.push_back(d);
      if (bHist.size() > B_DEPTH) void'(bHist.pop_front());
      s = '0;
      foreach (bHist[i]) s += bHist[i];
      bOutQ.push_back(s);
    end
    checkBit("b.window_full", bFull, bHist.size() == B_DEPTH);
    bInValid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic expValid, input logic [7:0] expData, input logic expFull);
    checkBit({name, ".valid"}, sOutValid, expValid);
    checkWord({name, ".data"}, 100'(sOutData), 100'(expData));
    checkBit({name, ".full"}, sFull, expFull);
  endtask

  initial begin
    logic [99:0] half;
    logic [99:0] w;
    half = 100'd1 << 99;

    tbl[0]  = '{1'b1, 1'b1, 8'd1,   1'b1, 1'b1, 8'd1,   1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'd2,   1'b1, 1'b1, 8'd3,   1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'd3,   1'b1, 1'b1, 8'd6,   1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'd4,   1'b1, 1'b1, 8'd10,  1'b1};
    tbl[4]  = '{1'b0, 1'b1, 8'd5,   1'b1, 1'b1, 8'd14,  1'b1};
    tbl[5]  = '{1'b0, 1'b1, 8'd6,   1'b1, 1'b1, 8'd18,  1'b1};
    tbl[6]  = '{1'b1, 1'b1, 8'd200, 1'b1, 1'b1, 8'd200, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'd100, 1'b1, 1'b1, 8'd44,  1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'd0,   1'b1, 1'b1, 8'd44,  1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'd0,   1'b1, 1'b1, 8'd44,  1'b1};
    tbl[10] = '{1'b0, 1'b1, 8'd0,   1'b1, 1'b1, 8'd100, 1'b1};

    // Reset state while rst is held
    rst = 1'b1;
    sInValid = 1'b0; sInData = '0; sOutReady = 1'b0; sFlush = 1'b0;
    bInValid = 1'b0; bInData = '0; bOutReady = 1'b0; bFlush = 1'b0;
    #12;
    checkBit("reset.out_valid", sOutValid, 1'b0);
    checkWord("reset.out_data", 100'(sOutData), 100'd0);
    checkBit("reset.window_full", sFull, 1'b0);
    checkBit("reset.in_ready", sInReady, 1'b1);
    checkWord("reset.big_out_data", bOutData, 100'd0);
    resetAll();

    // Table-driven sequences
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].doReset) resetAll();
      applyStimulus(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0);
      checkOutput($sformatf("tbl%0d", i), tbl[i].expValid, tbl[i].expData, tbl[i].expFull);
    end

    // Reset mid-stream with the FIFO full and the window full
    applyStimulus(1'b1, 8'd11, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd22, 1'b0, 1'b0);
    checkBit("midrst.pre_in_ready", sInReady, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkBit("midrst.out_valid", sOutValid, 1'b0);
    checkWord("midrst.out_data", 100'(sOutData), 100'd0);
    checkBit("midrst.window_full", sFull, 1'b0);
    checkBit("midrst.in_ready", sInReady, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    sHist.delete(); sOutQ.delete(); bHist.delete(); bOutQ.delete();
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 8'd7, 1'b1, 1'b0);
    checkOutput("midrst.after", 1'b1, 8'd7, 1'b0);

    // Backpressure
    resetAll();
    applyStimulus(1'b1, 8'd1, 1'b0, 1'b0);
    checkOutput("bp.1", 1'b1, 8'd1, 1'b0);
    applyStimulus(1'b1, 8'd2, 1'b0, 1'b0);
    checkOutput("bp.2", 1'b1, 8'd1, 1'b0);
    checkBit("bp.in_ready_low", sInReady, 1'b0);
    applyStimulus(1'b1, 8'd3, 1'b0, 1'b0);
    checkOutput("bp.held", 1'b1, 8'd1, 1'b0);
    applyStimulus(1'b1, 8'd3, 1'b1, 1'b0);
    checkOutput("bp.pop1", 1'b1, 8'd3, 1'b0);
    checkBit("bp.in_ready_back", sInReady, 1'b1);
    applyStimulus(1'b1, 8'd3, 1'b1, 1'b0);
    checkOutput("bp.sum6", 1'b1, 8'd6, 1'b0);

`ifdef WINDOW_SUM_FLUSH_EN
    // Flush with a simultaneous accept starts a fresh window
    resetAll();
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b0);
    checkOutput("flush.pre", 1'b1, 8'd15, 1'b0);
    applyStimulus(1'b1, 8'd9, 1'b1, 1'b1);
    checkOutput("flush.word", 1'b1, 8'd9, 1'b0);
    applyStimulus(1'b1, 8'd1, 1'b1, 1'b0);
    checkOutput("flush.next", 1'b1, 8'd10, 1'b0);
`endif

    // Randomized traffic on the small instance
    resetAll();
    for (int i = 0; i < 400; i++) begin
`ifdef WINDOW_SUM_FLUSH_EN
      applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 15) == 0);
`else
      applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0, 1'b0);
`endif
    end

    // Default instance: 2^99 repeated wraps modulo 2^100
    resetAll();
    for (int i = 0; i < 12; i++) begin
      stepBig(1'b1, half, 1'b1);
      checkWord($sformatf("big.half%0d", i), bOutData,
                (i < 10 && (i % 2) == 0) ? half : 100'd0);
      checkBit($sformatf("big.full%0d", i), bFull, i >= 9);
    end

    // Randomized traffic on the default instance
    resetAll();
    for (int i = 0; i < 200; i++) begin
      w = {4'($urandom), $urandom, $urandom, $urandom};
      stepBig($urandom_range(0, 3) != 0, w, $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
